// File: rtl/level_sequencer.sv
// Game flow sequencer: start screen, timed levels, level-done pause,
// finish and timeout screens driven by mouse clicks and frame ticks.
module level_sequencer #(
  parameter int N_LEVELS   = 4,
  parameter int COORD_W    = 12,
  parameter int FINISH_Y   = 500,
  parameter int BTN_X_MIN  = 160,
  parameter int BTN_X_MAX  = 650,
  parameter int BTN_Y_MIN  = 250,
  parameter int BTN_Y_MAX  = 320,
  parameter int LEVEL_TIME = 1800,
  parameter int DONE_TICKS = 120,
  localparam int LW = (N_LEVELS > 1) ? $clog2(N_LEVELS) : 1,
  localparam int TW = $clog2(LEVEL_TIME + 1)
) (
  input  logic               clk_40,
  input  logic               rst_n,
  input  logic               m_left,
  input  logic [COORD_W-1:0] xpos_mouse,
  input  logic [COORD_W-1:0] ypos_mouse,
  input  logic [COORD_W-1:0] ypos_player,
  input  logic               tick,
  output logic [2:0]         game_state,
  output logic [LW-1:0]      level,
  output logic [TW-1:0]      time_left,
  output logic               level_start
);

  localparam int DW = $clog2(DONE_TICKS + 1);

  localparam logic [COORD_W-1:0] X_MIN = COORD_W'(BTN_X_MIN);
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(BTN_X_MAX);
  localparam logic [COORD_W-1:0] Y_MIN = COORD_W'(BTN_Y_MIN);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(BTN_Y_MAX);
  localparam logic [COORD_W-1:0] FIN_Y = COORD_W'(FINISH_Y);
  localparam logic [TW-1:0]      T_FULL = TW'(LEVEL_TIME);
  localparam logic [DW-1:0]      D_LAST = DW'(DONE_TICKS);
  localparam logic [LW-1:0]      L_LAST = LW'(N_LEVELS - 1);

  typedef enum logic [2:0] {
    S_START   = 3'd0,
    S_PLAY    = 3'd1,
    S_DONE    = 3'd2,
    S_FINISH  = 3'd3,
    S_TIMEOUT = 3'd4
  } state_e;

  state_e        state_q;
  logic [LW-1:0] level_q;
  logic [TW-1:0] time_q;
  logic [DW-1:0] done_q;
  logic [DW-1:0] done_d;
  logic          start_q;
  logic          m_left_q;

  logic click;
  logic in_box;
  logic goal;

  assign click  = m_left & ~m_left_q;
  assign in_box = (xpos_mouse >= X_MIN) && (xpos_mouse <= X_MAX) &&
                  (ypos_mouse >= Y_MIN) && (ypos_mouse <= Y_MAX);
  assign goal   = ypos_player >= FIN_Y;
  assign done_d = done_q + DW'(1);

  always_ff @(posedge clk_40 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_START;
      level_q  <= '0;
      time_q   <= '0;
      done_q   <= '0;
      start_q  <= 1'b0;
      m_left_q <= 1'b0;
    end else begin
      m_left_q <= m_left;
      start_q  <= 1'b0;
      case (state_q)
        S_START: begin
          if (click && in_box) begin
            state_q <= S_PLAY;
            level_q <= '0;
            time_q  <= T_FULL;
            start_q <= 1'b1;
          end
        end
        // Goal wins over the last timer tick, freezing time_left.
        S_PLAY: begin
          if (goal) begin
            state_q <= S_DONE;
            done_q  <= '0;
          end else if (tick && time_q != '0) begin
            time_q <= time_q - TW'(1);
            if (time_q == TW'(1)) begin
              state_q <= S_TIMEOUT;
            end
          end
        end
        S_DONE: begin
          if (tick) begin
            done_q <= done_d;
            if (done_d == D_LAST) begin
              if (level_q == L_LAST) begin
                state_q <= S_FINISH;
              end else begin
                state_q <= S_PLAY;
                level_q <= level_q + LW'(1);
                time_q  <= T_FULL;
                start_q <= 1'b1;
              end
            end
          end
        end
        S_FINISH, S_TIMEOUT: begin
          if (click) begin
            state_q <= S_START;
            level_q <= '0;
            time_q  <= '0;
          end
        end
        default: begin
          state_q <= S_START;
          level_q <= '0;
          time_q  <= '0;
        end
      endcase
    end
  end

  assign game_state  = state_q;
  assign level       = level_q;
  assign time_left   = time_q;
  assign level_start = start_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Randomized bench for level_sequencer: two instances (default and a
// tiny one-level configuration) checked every cycle against a model.
module tb_level_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ml0 = 0, tk0 = 0;
  logic [11:0] x0 = 0, y0 = 0, yp0 = 0;
  logic [2:0]  gs0;
  logic [1:0]  lv0;
  logic [10:0] tl0;
  logic        ls0;

  logic        ml1 = 0, tk1 = 0;
  logic [11:0] x1 = 0, y1 = 0, yp1 = 0;
  logic [2:0]  gs1;
  logic [0:0]  lv1;
  logic [1:0]  tl1;
  logic        ls1;

  logic [16:0] o0;
  logic [6:0]  o1;
  assign o0 = {gs0, lv0, tl0, ls0};
  assign o1 = {gs1, lv1, tl1, ls1};

  level_sequencer u_dut0 (
    .clk_40(clk), .rst_n(rst_n), .m_left(ml0),
    .xpos_mouse(x0), .ypos_mouse(y0), .ypos_player(yp0),
    .tick(tk0), .game_state(gs0), .level(lv0),
    .time_left(tl0), .level_start(ls0)
  );

  level_sequencer #(
    .N_LEVELS(1), .LEVEL_TIME(3), .DONE_TICKS(2)
  ) u_dut1 (
    .clk_40(clk), .rst_n(rst_n), .m_left(ml1),
    .xpos_mouse(x1), .ypos_mouse(y1), .ypos_player(yp1),
    .tick(tk1), .game_state(gs1), .level(lv1),
    .time_left(tl1), .level_start(ls1)
  );

  typedef struct packed {
    int st;
    int lvl;
    int tl;
    int dc;
    bit ls;
    bit prev;
  } mdl_t;

  mdl_t m0 = '0, m1 = '0;
  int nvec = 0, nerr = 0;

  // Game rules: 0 start, 1 play, 2 level done, 3 finish, 4 timeout.
  function automatic mdl_t step(mdl_t m, logic ml, int x, int y,
                                int yp, logic tk, int nl, int lt,
                                int dt);
    mdl_t n = m;
    bit click = ml && !m.prev;
    bit inbox = x >= 160 && x <= 650 && y >= 250 && y <= 320;
    n.prev = ml;
    n.ls = 0;
    case (m.st)
      0: if (click && inbox) begin
        n.st = 1; n.lvl = 0; n.tl = lt; n.ls = 1;
      end
      1: if (yp >= 500) begin
        n.st = 2; n.dc = 0;
      end else if (tk) begin
        n.tl = m.tl - 1;
        if (n.tl == 0) n.st = 4;
      end
      2: if (tk) begin
        n.dc = m.dc + 1;
        if (n.dc == dt) begin
          if (m.lvl == nl - 1) n.st = 3;
          else begin
            n.st = 1; n.lvl = m.lvl + 1; n.tl = lt; n.ls = 1;
          end
        end
      end
      default: if (click) begin
        n.st = 0; n.lvl = 0; n.tl = 0;
      end
    endcase
    return n;
  endfunction

  function automatic logic [16:0] e0(mdl_t m);
    return {3'(m.st), 2'(m.lvl), 11'(m.tl), m.ls};
  endfunction

  function automatic logic [6:0] e1(mdl_t m);
    return {3'(m.st), 1'(m.lvl), 2'(m.tl), m.ls};
  endfunction

  task automatic clk_step();
    @(posedge clk);
    if (!rst_n) begin
      m0 = '0;
      m1 = '0;
    end else begin
      m0 = step(m0, ml0, int'(x0), int'(y0), int'(yp0), tk0,
                4, 1800, 120);
      m1 = step(m1, ml1, int'(x1), int'(y1), int'(yp1), tk1,
                1, 3, 2);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clk_step();
    clk_step();
    if (o0 !== 17'd0) begin
      nerr++; $display("FAIL reset0: got %h want 0", o0);
    end
    nvec++;
    if (o1 !== 7'd0) begin
      nerr++; $display("FAIL reset1: got %h want 0", o1);
    end
    nvec++;
    #2 rst_n = 1;
  endtask

  task automatic test_start_box();
    int bx[5] = '{100, 159, 651, 400, 400};
    int by[5] = '{300, 300, 300, 249, 321};
    for (int i = 0; i < 5; i++) begin
      x0 = 12'(bx[i]); y0 = 12'(by[i]);
      ml0 = 1; clk_step();
      if (o0 !== e0(m0)) begin
        nerr++; $display("FAIL start_out %0d: got %h want %h",
                         i, o0, e0(m0));
      end
      nvec++;
      ml0 = 0; clk_step();
      if (gs0 !== 3'd0) begin
        nerr++; $display("FAIL start_stay %0d: got %0d want 0", i, gs0);
      end
      nvec++;
    end
    x0 = 400; y0 = 300; ml0 = 1; clk_step();
    if (gs0 !== 3'd1 || lv0 !== 2'd0 || tl0 !== 11'd1800 ||
        ls0 !== 1'b1) begin
      nerr++; $display("FAIL start_in: got %h want %h", o0, e0(m0));
    end
    nvec++;
    clk_step();
    if (o0 !== e0(m0) || ls0 !== 1'b0) begin
      nerr++; $display("FAIL start_pulse: got %h want %h", o0, e0(m0));
    end
    nvec++;
  endtask

  task automatic test_level_flow();
    yp0 = 500;
    for (int i = 0; i < 4000 && m0.st != 3; i++) begin
      tk0 = 1'($urandom_range(0, 1));
      ml0 = 1'($urandom_range(0, 1));
      clk_step();
      if (o0 !== e0(m0)) begin
        nerr++; $display("FAIL level_flow cyc %0d: got %h want %h",
                         i, o0, e0(m0));
      end
      nvec++;
    end
    if (gs0 !== 3'd3 || lv0 !== 2'd3) begin
      nerr++; $display("FAIL level_finish: got st %0d lvl %0d want 3 3",
                       gs0, lv0);
    end
    nvec++;
    tk0 = 0; yp0 = 0; ml0 = 0;
  endtask

  task automatic test_finish_hold();
    clk_step();
    x0 = 400; y0 = 300; ml0 = 1;
    for (int i = 0; i < 50; i++) begin
      clk_step();
      if (o0 !== e0(m0)) begin
        nerr++; $display("FAIL finish_hold cyc %0d: got %h want %h",
                         i, o0, e0(m0));
      end
      nvec++;
    end
    if (gs0 !== 3'd0) begin
      nerr++; $display("FAIL finish_hold_end: got %0d want 0", gs0);
    end
    nvec++;
    ml0 = 0; clk_step();
  endtask

  task automatic test_timeout();
    x0 = 650; y0 = 320; ml0 = 1; clk_step();
    ml0 = 0;
    for (int i = 0; i < 8000 && m0.st != 4; i++) begin
      tk0 = 1'($urandom_range(0, 1));
      yp0 = 12'($urandom_range(0, 499));
      ml0 = 1'($urandom_range(0, 1));
      x0 = 12'($urandom_range(0, 800));
      clk_step();
      if (o0 !== e0(m0)) begin
        nerr++; $display("FAIL timeout cyc %0d: got %h want %h",
                         i, o0, e0(m0));
      end
      nvec++;
    end
    if (gs0 !== 3'd4 || tl0 !== 11'd0) begin
      nerr++; $display("FAIL timeout_end: got st %0d tl %0d want 4 0",
                       gs0, tl0);
    end
    nvec++;
    tk0 = 0; x0 = 0; y0 = 0;
    ml0 = 0; clk_step();
    ml0 = 1; clk_step();
    if (o0 !== 17'd0) begin
      nerr++; $display("FAIL timeout_click: got %h want 0", o0);
    end
    nvec++;
    ml0 = 0; clk_step();
  endtask

  task automatic test_small();
    int rm[14]  = '{1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0};
    int rx[14]  = '{400, 0, 0, 0, 0, 0, 160, 0, 0, 0, 0, 0, 9, 0};
    int ry[14]  = '{300, 0, 0, 0, 0, 0, 250, 0, 0, 0, 0, 0, 9, 0};
    int ryp[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 500, 0, 0, 0, 0};
    int rt[14]  = '{0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0};
    int es[14]  = '{1, 1, 1, 4, 0, 0, 1, 1, 1, 2, 2, 3, 0, 0};
    int et[14]  = '{3, 2, 1, 0, 0, 0, 3, 2, 1, 1, 1, 1, 0, 0};
    for (int i = 0; i < 14; i++) begin
      ml1 = 1'(rm[i]); x1 = 12'(rx[i]); y1 = 12'(ry[i]);
      yp1 = 12'(ryp[i]); tk1 = 1'(rt[i]);
      clk_step();
      if (o1 !== e1(m1) || gs1 !== 3'(es[i]) ||
          tl1 !== 2'(et[i]) || lv1 !== 1'b0) begin
        nerr++; $display("FAIL small row %0d: got %h want st %0d tl %0d",
                         i, o1, es[i], et[i]);
      end
      nvec++;
    end
    ml1 = 0; tk1 = 0; yp1 = 0;
  endtask

  task automatic test_async_reset();
    x0 = 400; y0 = 300; yp0 = 0; ml0 = 1; clk_step();
    ml0 = 0; tk0 = 1;
    repeat (3) clk_step();
    tk0 = 0;
    #2 rst_n = 0;
    #1;
    if (o0 !== 17'd0) begin
      nerr++; $display("FAIL async_reset0: got %h want 0", o0);
    end
    nvec++;
    if (o1 !== 7'd0) begin
      nerr++; $display("FAIL async_reset1: got %h want 0", o1);
    end
    nvec++;
    m0 = '0; m1 = '0;
    clk_step();
    #2 rst_n = 1;
    clk_step();
    if (o0 !== 17'd0) begin
      nerr++; $display("FAIL async_wait: got %h want 0", o0);
    end
    nvec++;
  endtask

  task automatic test_reset_click();
    #2 rst_n = 0;
    x0 = 400; y0 = 300; ml0 = 1;
    clk_step();
    #2 rst_n = 1;
    clk_step();
    if (o0 !== e0(m0) || gs0 !== 3'd1 || ls0 !== 1'b1) begin
      nerr++; $display("FAIL reset_click: got %h want %h", o0, e0(m0));
    end
    nvec++;
    ml0 = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      ml0 = 1'($urandom_range(0, 3) == 0);
      x0 = 12'($urandom_range(100, 700));
      y0 = 12'($urandom_range(200, 370));
      yp0 = ($urandom_range(0, 15) == 0) ?
            12'($urandom_range(500, 600)) : 12'($urandom_range(0, 499));
      tk0 = 1'($urandom_range(0, 1));
      ml1 = 1'($urandom_range(0, 3) == 0);
      x1 = 12'($urandom_range(100, 700));
      y1 = 12'($urandom_range(200, 370));
      yp1 = ($urandom_range(0, 7) == 0) ? 12'd500 : 12'd10;
      tk1 = 1'($urandom_range(0, 1));
      clk_step();
      if (o0 !== e0(m0)) begin
        nerr++; $display("FAIL random0 cyc %0d: got %h want %h",
                         i, o0, e0(m0));
      end
      nvec++;
      if (o1 !== e1(m1)) begin
        nerr++; $display("FAIL random1 cyc %0d: got %h want %h",
                         i, o1, e1(m1));
      end
      nvec++;
    end
  endtask

  initial begin
    test_reset();
    test_start_box();
    test_level_flow();
    test_finish_hold();
    test_timeout();
    test_small();
    test_async_reset();
    test_reset_click();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
